// File: rtl/jelly_texture_border_scan_pkg.sv
// Shared types for the border-unit raster scan sequencer.
package jelly_texture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } scan_state_t;

endpackage

// File: rtl/jelly_texture_border_scan_if.sv
// Coordinate stream towards the border unit plus the monitored response handshake.
interface jelly_texture_border_scan_if #(
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 10
) ();

  // Valid/ready: a transfer happens on a clock edge where valid && ready;
  // while valid is high and ready low the payload must not change.
  logic signed [X_WIDTH-1:0] m_x;
  logic signed [Y_WIDTH-1:0] m_y;
  logic                      m_valid;
  logic                      m_ready;
  logic                      resp_valid;
  logic                      resp_ready;

  modport master (
    output m_x, m_y, m_valid,
    input  m_ready, resp_valid, resp_ready
  );

  modport slave (
    input  m_x, m_y, m_valid,
    output m_ready, resp_valid, resp_ready
  );

endinterface

// File: rtl/jelly_texture_border_scan.sv
// Row-major (x,y) issuer for a signed window; pulses done once every issued
// coordinate has come back through the border unit's output handshake.
module jelly_texture_border_scan
  import jelly_texture_pkg::*;
#(
  parameter int X_WIDTH      = 11,
  parameter int Y_WIDTH      = 10,
  parameter int SIZE_X_WIDTH = 11,
  parameter int SIZE_Y_WIDTH = 10,
  parameter int COUNT_WIDTH  = SIZE_X_WIDTH + SIZE_Y_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic                          start,
  input  logic signed [X_WIDTH-1:0]     param_x0,
  input  logic signed [Y_WIDTH-1:0]     param_y0,
  input  logic [SIZE_X_WIDTH-1:0]       param_w,
  input  logic [SIZE_Y_WIDTH-1:0]       param_h,
  output logic                          busy,
  output logic                          done,
  output scan_state_t                   dbg_state,
  output logic [COUNT_WIDTH-1:0]        dbg_issue_cnt,
  jelly_texture_border_scan_if.master   m_if
);

  scan_state_t                  r_state;
  scan_state_t                  w_next;
  logic                         r_done;
  logic                         w_done_set;
  logic                         r_valid;
  logic signed [X_WIDTH-1:0]    r_x0;
  logic signed [X_WIDTH-1:0]    r_x;
  logic signed [Y_WIDTH-1:0]    r_y;
  logic [SIZE_X_WIDTH-1:0]      r_w;
  logic [SIZE_X_WIDTH-1:0]      r_col;
  logic [SIZE_Y_WIDTH-1:0]      r_h;
  logic [SIZE_Y_WIDTH-1:0]      r_row;
  logic [COUNT_WIDTH-1:0]       r_total;
  logic [COUNT_WIDTH-1:0]       r_issue_cnt;
  logic [COUNT_WIDTH-1:0]       r_resp_cnt;

  // The done cycle still belongs to the finishing scan, so a start there is dropped.
  wire w_start    = start && (r_state == IDLE) && !r_done;
  wire w_empty    = (param_w == '0) || (param_h == '0);
  wire w_fire     = r_valid && m_if.m_ready;
  wire w_col_last = (r_col == r_w - SIZE_X_WIDTH'(1));
  wire w_row_last = (r_row == r_h - SIZE_Y_WIDTH'(1));
  wire w_last     = w_fire && w_col_last && w_row_last;
  wire w_resp     = m_if.resp_valid && m_if.resp_ready && ((r_state == RUN) || (r_state == DRAIN));
  wire w_drained  = (r_state == DRAIN) && (r_resp_cnt == r_total);

  always_comb begin
    w_next     = r_state;
    w_done_set = 1'b0;
    case (r_state)
      IDLE:    if (w_start) w_next = w_empty ? FLUSH : RUN;
      RUN:     if (w_last) w_next = DRAIN;
      DRAIN: begin
        if (w_drained) begin
          w_next     = IDLE;
          w_done_set = 1'b1;
        end
      end
      FLUSH: begin
        w_next     = IDLE;
        w_done_set = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_x0        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_w         <= '0;
      r_col       <= '0;
      r_h         <= '0;
      r_row       <= '0;
      r_total     <= '0;
      r_issue_cnt <= '0;
      r_resp_cnt  <= '0;
    end else if (cke) begin
      r_state <= w_next;
      r_done  <= w_done_set;
      if (w_start) begin
        r_x0        <= param_x0;
        r_x         <= param_x0;
        r_y         <= param_y0;
        r_w         <= param_w;
        r_h         <= param_h;
        r_col       <= '0;
        r_row       <= '0;
        r_total     <= COUNT_WIDTH'(param_w) * COUNT_WIDTH'(param_h);
        r_issue_cnt <= '0;
        r_resp_cnt  <= '0;
        r_valid     <= !w_empty;
      end else begin
        if (w_fire) begin
          r_issue_cnt <= r_issue_cnt + COUNT_WIDTH'(1);
          if (w_col_last) begin
            r_x   <= r_x0;
            r_y   <= r_y + Y_WIDTH'(1);
            r_col <= '0;
            r_row <= r_row + SIZE_Y_WIDTH'(1);
          end else begin
            r_x   <= r_x + X_WIDTH'(1);
            r_col <= r_col + SIZE_X_WIDTH'(1);
          end
          if (w_last) r_valid <= 1'b0;
        end
        if (w_resp) r_resp_cnt <= r_resp_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign dbg_state     = r_state;
  assign dbg_issue_cnt = r_issue_cnt;
  assign m_if.m_x      = r_x;
  assign m_if.m_y      = r_y;
  assign m_if.m_valid  = r_valid;

endmodule

// File: tb/tb_jelly_texture_border_scan.sv
// Bench for the raster scan sequencer; an in-bench responder stands in for the border unit.
module tb_jelly_texture_border_scan;
  import jelly_texture_pkg::*;

  localparam int MAX_CYC = 40000;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cke = 1'b1;
  logic                start = 1'b0;
  logic signed [10:0]  param_x0 = '0;
  logic signed [9:0]   param_y0 = '0;
  logic [10:0]         param_w = '0;
  logic [9:0]          param_h = '0;
  logic                busy;
  logic                done;
  scan_state_t         dbg_state;
  logic [20:0]         dbg_issue_cnt;

  jelly_texture_border_scan_if #(.X_WIDTH(11), .Y_WIDTH(10)) bus ();

  jelly_texture_border_scan #(
    .X_WIDTH(11), .Y_WIDTH(10), .SIZE_X_WIDTH(11), .SIZE_Y_WIDTH(10)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke), .start(start),
    .param_x0(param_x0), .param_y0(param_y0), .param_w(param_w), .param_h(param_h),
    .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_issue_cnt(dbg_issue_cnt),
    .m_if(bus.master)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  int n_done, done_at, resp_at_done, pend_at_done, busy_cyc, first_valid, last_fire;
  int n_valid_cyc, stall_err, cke_err, tail_busy, tail_valid, n_resp, pending;
  logic ab_valid, ab_busy;

  // Reference: every (x,y) of the window in row-major order, packed {y,x}.
  function automatic void build_model(input int x0, input int y0, input int w, input int h);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back({10'(y0 + r), 11'(x0 + c)});
  endfunction

  function automatic int seq_mismatches();
    int bad = 0;
    if (obs_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic run_scan(input int x0, input int y0, input int w, input int h,
                          input int rdy_pct, input int resp_div, input int cke_at,
                          input int abort_at, input int restart_at, input bit start_on_done);
    int cyc, tail;
    bit fired_prev, valid_prev, cke_prev;
    logic signed [10:0] px;
    logic signed [9:0] py;
    logic [23:0] snap;
    obs_q.delete();
    n_done = 0; done_at = -1; resp_at_done = -1; pend_at_done = -1; busy_cyc = 0;
    first_valid = -1; last_fire = -1; n_valid_cyc = 0; stall_err = 0; cke_err = 0;
    tail_busy = 0; tail_valid = 0; n_resp = 0; pending = 0; ab_valid = 1'bx; ab_busy = 1'bx;
    @(negedge clk);
    param_x0 = 11'(x0); param_y0 = 10'(y0); param_w = 11'(w); param_h = 10'(h);
    start = 1'b1; cke = 1'b1; bus.m_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    param_x0 = 11'($urandom); param_y0 = 10'($urandom);
    param_w = 11'($urandom); param_h = 10'($urandom);
    cyc = 1; tail = -1; fired_prev = 0; valid_prev = 0; cke_prev = 1; px = '0; py = '0; snap = '0;
    while (cyc < MAX_CYC) begin
      if (!cke_prev) begin
        if ({bus.m_valid, bus.m_x, bus.m_y, busy, done} !== snap) cke_err++;
      end else if (valid_prev && !fired_prev) begin
        if (bus.m_valid !== 1'b1 || bus.m_x !== px || bus.m_y !== py) stall_err++;
      end
      if (tail >= 0) begin
        if (busy) tail_busy++;
        if (bus.m_valid) tail_valid++;
      end else if (busy) busy_cyc++;
      if (bus.m_valid) begin
        n_valid_cyc++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (done && cke_prev) begin
        n_done++;
        if (done_at < 0) begin
          done_at = cyc; resp_at_done = n_resp; pend_at_done = pending;
        end
      end
      if (tail >= 0) tail++;
      else if (done_at >= 0) tail = 0;
      if (tail > 4) break;
      if (abort_at >= 0 && obs_q.size() == abort_at) begin
        reset = 1'b1; bus.m_ready = 1'b0; start = 1'b0; cke = 1'b1;
        @(negedge clk);
        ab_valid = bus.m_valid; ab_busy = busy;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (done) n_done++;
          if (bus.m_valid) tail_valid++;
        end
        return;
      end
      cke = !(cke_at >= 0 && cyc >= cke_at && cyc < cke_at + 10);
      bus.m_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.resp_valid = (pending > 0);
      bus.resp_ready = (resp_div <= 1) || ($urandom_range(0, resp_div - 1) == 0);
      start = (cyc == restart_at) || (start_on_done && done && cke_prev);
      if (start) begin
        param_x0 = 11'($urandom_range(0, 100)); param_y0 = 10'($urandom_range(0, 100));
        param_w = 11'($urandom_range(1, 4)); param_h = 10'($urandom_range(1, 4));
      end
      fired_prev = cke && bus.m_valid && bus.m_ready;
      if (fired_prev) begin
        obs_q.push_back({bus.m_y, bus.m_x});
        last_fire = cyc;
      end
      if (cke && bus.resp_valid && bus.resp_ready) begin
        pending--; n_resp++;
      end
      if (fired_prev) pending++;
      valid_prev = bus.m_valid; px = bus.m_x; py = bus.m_y; cke_prev = cke;
      snap = {bus.m_valid, bus.m_x, bus.m_y, busy, done};
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; cke = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cke = 1'b1; start = 1'b0;
    bus.m_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      n_total++; if (bus.m_x !== 11'sd0 || bus.m_y !== 10'sd0) $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", bus.m_x, bus.m_y); else n_pass++;
      n_total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); else n_pass++;
      n_total++; if (dbg_issue_cnt !== 21'd0) $display("FAIL reset_issue_cnt: got %0d expected 0", dbg_issue_cnt); else n_pass++;
      reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_full_scan();
    logic [20:0] e;
    int bad;
    run_scan(-10, -10, 84, 68, 100, 1, -1, -1, -1, 1'b0);
    build_model(-10, -10, 84, 68);
    bad = seq_mismatches();
    n_total++; if (bad !== 0) $display("FAIL full_seq: %0d mismatches, got %0d coords expected %0d", bad, obs_q.size(), exp_q.size()); else n_pass++;
    n_total++; if (obs_q.size() !== 5712) $display("FAIL full_count: got %0d expected 5712", obs_q.size()); else n_pass++;
    if (obs_q.size() == 5712) begin
      e = obs_q[0];
      n_total++; if ($signed(e[10:0]) !== -11'sd10 || $signed(e[20:11]) !== -10'sd10) $display("FAIL full_first: got (%0d,%0d) expected (-10,-10)", $signed(e[10:0]), $signed(e[20:11])); else n_pass++;
      e = obs_q[83];
      n_total++; if ($signed(e[10:0]) !== 11'sd73 || $signed(e[20:11]) !== -10'sd10) $display("FAIL full_row_end: got (%0d,%0d) expected (73,-10)", $signed(e[10:0]), $signed(e[20:11])); else n_pass++;
      e = obs_q[84];
      n_total++; if ($signed(e[10:0]) !== -11'sd10 || $signed(e[20:11]) !== -10'sd9) $display("FAIL full_row_wrap: got (%0d,%0d) expected (-10,-9)", $signed(e[10:0]), $signed(e[20:11])); else n_pass++;
      e = obs_q[5711];
      n_total++; if ($signed(e[10:0]) !== 11'sd73 || $signed(e[20:11]) !== 10'sd57) $display("FAIL full_last: got (%0d,%0d) expected (73,57)", $signed(e[10:0]), $signed(e[20:11])); else n_pass++;
    end
    n_total++; if (n_done !== 1) $display("FAIL full_done_count: got %0d expected 1", n_done); else n_pass++;
    n_total++; if (first_valid !== 1) $display("FAIL full_latency: got %0d expected 1", first_valid); else n_pass++;
    n_total++; if (last_fire - first_valid + 1 !== 5712) $display("FAIL full_throughput: got %0d cycles expected 5712", last_fire - first_valid + 1); else n_pass++;
    n_total++; if (resp_at_done !== 5712) $display("FAIL full_resp_at_done: got %0d expected 5712", resp_at_done); else n_pass++;
    n_total++; if (busy_cyc !== done_at - 1) $display("FAIL full_busy_span: got %0d expected %0d", busy_cyc, done_at - 1); else n_pass++;
    n_total++; if (dbg_issue_cnt !== 21'd5712) $display("FAIL full_issue_cnt: got %0d expected 5712", dbg_issue_cnt); else n_pass++;
    n_total++; if (tail_busy !== 0 || tail_valid !== 0) $display("FAIL full_tail_idle: got busy %0d valid %0d expected 0 0", tail_busy, tail_valid); else n_pass++;
  endtask

  task automatic test_random_ready();
    int bad;
    run_scan(-10, -10, 84, 68, 50, 1, -1, -1, -1, 1'b0);
    build_model(-10, -10, 84, 68);
    bad = seq_mismatches();
    n_total++; if (bad !== 0) $display("FAIL stall_seq: %0d mismatches, got %0d coords expected %0d", bad, obs_q.size(), exp_q.size()); else n_pass++;
    n_total++; if (stall_err !== 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL stall_done_count: got %0d expected 1", n_done); else n_pass++;
    n_total++; if (first_valid !== 1) $display("FAIL stall_latency: got %0d expected 1", first_valid); else n_pass++;
  endtask

  task automatic test_empty();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_scan(3, 4, 0, 5, 100, 1, -1, -1, -1, 1'b0);
      else        run_scan(-3, 2, 3, 0, 100, 1, -1, -1, -1, 1'b0);
      n_total++; if (n_valid_cyc !== 0) $display("FAIL empty%0d_valid: got %0d valid cycles expected 0", k, n_valid_cyc); else n_pass++;
      n_total++; if (done_at !== 2) $display("FAIL empty%0d_done_at: got %0d expected 2", k, done_at); else n_pass++;
      n_total++; if (busy_cyc !== 1) $display("FAIL empty%0d_busy: got %0d expected 1", k, busy_cyc); else n_pass++;
      n_total++; if (n_done !== 1) $display("FAIL empty%0d_done_count: got %0d expected 1", k, n_done); else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [20:0] e;
    run_scan(5, 7, 1, 1, 100, 1, -1, -1, 2, 1'b1);
    n_total++; if (obs_q.size() !== 1) $display("FAIL single_count: got %0d expected 1", obs_q.size()); else n_pass++;
    if (obs_q.size() >= 1) begin
      e = obs_q[0];
      n_total++; if ($signed(e[10:0]) !== 11'sd5 || $signed(e[20:11]) !== 10'sd7) $display("FAIL single_coord: got (%0d,%0d) expected (5,7)", $signed(e[10:0]), $signed(e[20:11])); else n_pass++;
    end
    n_total++; if (n_done !== 1) $display("FAIL single_done_count: got %0d expected 1", n_done); else n_pass++;
    n_total++; if (resp_at_done !== 1 || pend_at_done !== 0) $display("FAIL single_resp: got %0d resp %0d pending expected 1 0", resp_at_done, pend_at_done); else n_pass++;
    n_total++; if (tail_busy !== 0 || tail_valid !== 0) $display("FAIL single_start_on_done: got busy %0d valid %0d expected 0 0", tail_busy, tail_valid); else n_pass++;
  endtask

  task automatic test_resp_throttle();
    int bad;
    run_scan(-10, -10, 84, 68, 100, 4, 200, -1, -1, 1'b0);
    build_model(-10, -10, 84, 68);
    bad = seq_mismatches();
    n_total++; if (bad !== 0) $display("FAIL throttle_seq: %0d mismatches, got %0d coords expected %0d", bad, obs_q.size(), exp_q.size()); else n_pass++;
    n_total++; if (resp_at_done !== 5712 || pend_at_done !== 0) $display("FAIL throttle_resp_at_done: got %0d resp %0d pending expected 5712 0", resp_at_done, pend_at_done); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL throttle_done_count: got %0d expected 1", n_done); else n_pass++;
    n_total++; if (cke_err !== 0) $display("FAIL cke_freeze: got %0d changed cycles expected 0", cke_err); else n_pass++;
    n_total++; if (stall_err !== 0) $display("FAIL throttle_hold: got %0d unstable cycles expected 0", stall_err); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int bad;
    run_scan(-10, -10, 84, 68, 100, 1, -1, 100, -1, 1'b0);
    n_total++; if (obs_q.size() !== 100) $display("FAIL abort_issued: got %0d expected 100", obs_q.size()); else n_pass++;
    n_total++; if (ab_valid !== 1'b0 || ab_busy !== 1'b0) $display("FAIL abort_clear: got valid %b busy %b expected 0 0", ab_valid, ab_busy); else n_pass++;
    n_total++; if (n_done !== 0 || tail_valid !== 0) $display("FAIL abort_quiet: got %0d done %0d valid expected 0 0", n_done, tail_valid); else n_pass++;
    run_scan(-10, -10, 84, 68, 100, 1, -1, -1, -1, 1'b0);
    build_model(-10, -10, 84, 68);
    bad = seq_mismatches();
    n_total++; if (bad !== 0) $display("FAIL abort_rescan_seq: %0d mismatches, got %0d coords expected %0d", bad, obs_q.size(), exp_q.size()); else n_pass++;
    n_total++; if (n_done !== 1) $display("FAIL abort_rescan_done: got %0d expected 1", n_done); else n_pass++;
  endtask

  initial begin
    bus.m_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_full_scan();
    test_random_ready();
    test_empty();
    test_single();
    test_resp_throttle();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
